// File: rtl/sfx_tone_engine.sv
// sfx_tone_engine: background tone plus N_CH prioritised sound-effect channels.
// A small FSM picks the tone source (background, effect channel or silence).
// A square-wave generator toggles at the selected half-period. The square is
// gated by a carrier PWM, which sets the volume, and drives the PMOD audio amp.
module sfx_tone_engine #(
  parameter int N_CH      = 4,
  parameter int HP_W      = 20,
  parameter int LEN_W     = 8,
  parameter int DUTY_W    = 8,
  parameter int GAP_TICKS = 2,
  localparam int CH_W     = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic [HP_W-1:0]        bg_hp,
  input  logic [N_CH-1:0]        sfx_req,
  input  logic [N_CH*HP_W-1:0]   sfx_hp,
  input  logic [N_CH*LEN_W-1:0]  sfx_len,
  input  logic [DUTY_W-1:0]      volume,
  input  logic                   mute,
  output logic                   busy,
  output logic [CH_W-1:0]        active_ch,
  output logic [N_CH-1:0]        done,
  output logic                   pmod_1,
  output logic                   pmod_2,
  output logic                   pmod_4
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SFX  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  logic [1:0]       state, state_n;
  logic [N_CH-1:0]  pending, pending_n;
  logic [CH_W-1:0]  ch_n;
  logic [LEN_W-1:0] rem, rem_n;
  logic [GW-1:0]    gcnt, gcnt_n;
  logic [HP_W-1:0]  act_hp, act_hp_n;
  logic [N_CH-1:0]  done_n;

  logic             low_any;
  logic [CH_W-1:0]  low_idx;
  logic [HP_W-1:0]  hp_sel;
  logic [LEN_W-1:0] len_sel;
  logic             grant;
  logic [N_CH-1:0]  grant_mask;

  logic [HP_W-1:0]   tone_hp;
  logic [HP_W-1:0]   cnt;
  logic              square;
  logic [CH_W+1:0]   src, src_q;
  logic [DUTY_W-1:0] c;
  logic              carrier;

  // Lowest-index pending channel, plus the parameters it would be granted with.
  always_comb begin
    low_any = 1'b0;
    low_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        low_any = 1'b1;
        low_idx = CH_W'(i);
      end
    end
    hp_sel  = sfx_hp[low_idx*HP_W +: HP_W];
    len_sel = sfx_len[low_idx*LEN_W +: LEN_W];
  end

  // Sequencing: grants, effect duration, preemption and post-effect gap.
  // A tick with rem==1 completes the current effect even if a higher-priority
  // request is also waiting; that request is served after the gap.
  always_comb begin
    // NOTE: every signal gets a default value first, so no path through the case leaves it unassigned and no latch is inferred.
    state_n    = state;
    ch_n       = active_ch;
    rem_n      = rem;
    gcnt_n     = gcnt;
    act_hp_n   = act_hp;
    done_n     = '0;
    grant      = 1'b0;
    grant_mask = '0;
    case (state)
      ST_IDLE: begin
        if (low_any) grant = 1'b1;
      end
      ST_SFX: begin
        if (tick && rem == LEN_W'(1)) begin
          done_n[active_ch] = 1'b1;
          if (GAP_TICKS > 0) begin
            state_n = ST_GAP;
            gcnt_n  = GW'(GAP_TICKS);
          end else begin
            state_n = ST_IDLE;
          end
        end else if (low_any && low_idx < active_ch) begin
          grant = 1'b1;
        end else if (tick) begin
          rem_n = rem - LEN_W'(1);
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (gcnt <= GW'(1)) begin
            if (low_any) grant = 1'b1;
            else         state_n = ST_IDLE;
          end else begin
            gcnt_n = gcnt - GW'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (grant) begin
      state_n             = ST_SFX;
      ch_n                = low_idx;
      rem_n               = (len_sel == '0) ? LEN_W'(1) : len_sel;
      act_hp_n            = hp_sel;
      grant_mask[low_idx] = 1'b1;
    end
    // A request in the grant cycle re-queues the channel: set wins over clear.
    pending_n = (pending & ~grant_mask) | sfx_req;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      pending   <= '0;
      active_ch <= '0;
      rem       <= '0;
      gcnt      <= '0;
      act_hp    <= '0;
      done      <= '0;
    end else begin
      // NOTE: non-blocking assignments let every register sample the pre-edge values, so the order of these lines does not matter.
      state     <= state_n;
      pending   <= pending_n;
      active_ch <= ch_n;
      rem       <= rem_n;
      gcnt      <= gcnt_n;
      act_hp    <= act_hp_n;
      done      <= done_n;
    end
  end

  // Tone source select: background, the latched effect half-period, or silence.
  always_comb begin
    tone_hp = '0;
    case (state)
      ST_IDLE: tone_hp = bg_hp;
      ST_SFX:  tone_hp = act_hp;
      default: tone_hp = '0;
    endcase
  end

  assign src = {state, active_ch};

  // Square-wave generator; restarts high whenever the tone source changes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      square <= 1'b0;
      src_q  <= {ST_IDLE, {CH_W{1'b0}}};
    end else begin
      src_q <= src;
      if (tone_hp == '0) begin
        cnt    <= '0;
        square <= 1'b0;
      end else if (src != src_q) begin
        cnt    <= '0;
        square <= 1'b1;
      end else if (cnt >= tone_hp - HP_W'(1)) begin
        cnt    <= '0;
        square <= ~square;
      end else begin
        cnt <= cnt + HP_W'(1);
      end
    end
  end

  assign carrier = (c < volume);

  // Free-running carrier counter and registered amp outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c      <= '0;
      pmod_1 <= 1'b0;
      pmod_4 <= 1'b0;
    end else begin
      c      <= c + DUTY_W'(1);
      pmod_1 <= square & carrier & ~mute;
      pmod_4 <= ~mute;
    end
  end

  assign pmod_2 = 1'b1;
  assign busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_sfx_tone_engine.sv
// Testbench for sfx_tone_engine: directed scenarios plus randomized traffic,
// every cycle compared against an event-level behavioural model.
module tb_sfx_tone_engine;
  localparam int N_CH      = 4;
  localparam int HP_W      = 20;
  localparam int LEN_W     = 8;
  localparam int DUTY_W    = 8;
  localparam int GAP_TICKS = 2;
  localparam int CH_W      = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  tick = 1'b0;
  logic [HP_W-1:0]       bg_hp = '0;
  logic [N_CH-1:0]       sfx_req = '0;
  logic [N_CH*HP_W-1:0]  sfx_hp = '0;
  logic [N_CH*LEN_W-1:0] sfx_len = '0;
  logic [DUTY_W-1:0]     volume = '0;
  logic                  mute = 1'b0;
  logic                  busy;
  logic [CH_W-1:0]       active_ch;
  logic [N_CH-1:0]       done;
  logic                  pmod_1, pmod_2, pmod_4;

  sfx_tone_engine #(
    .N_CH(N_CH), .HP_W(HP_W), .LEN_W(LEN_W), .DUTY_W(DUTY_W), .GAP_TICKS(GAP_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .bg_hp(bg_hp), .sfx_req(sfx_req),
    .sfx_hp(sfx_hp), .sfx_len(sfx_len), .volume(volume), .mute(mute),
    .busy(busy), .active_ch(active_ch), .done(done),
    .pmod_1(pmod_1), .pmod_2(pmod_2), .pmod_4(pmod_4)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum {M_IDLE, M_PLAY, M_QUIET} mmode_t;
  mmode_t          m_mode;
  int              m_ch, m_left, m_gap, m_hp;
  bit              m_pend [N_CH];
  bit [N_CH-1:0]   m_done;
  int              m_k, seg_start, seg_hp, m_c;
  bit              seg_init, restart_due, m_sq, m_pmod1, m_pmod4;

  function automatic int hp_of(input int i);
    return int'(sfx_hp[i*HP_W +: HP_W]);
  endfunction

  function automatic int len_of(input int i);
    return int'(sfx_len[i*LEN_W +: LEN_W]);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_ch = 0; m_left = 0; m_gap = 0; m_hp = 0; m_done = '0;
    for (int i = 0; i < N_CH; i++) m_pend[i] = 1'b0;
    m_k = 0; seg_start = 0; seg_hp = int'(bg_hp); seg_init = 1'b0;
    restart_due = 1'b0; m_sq = 1'b0; m_pmod1 = 1'b0; m_pmod4 = 1'b0; m_c = 0;
  endtask

  // One clock edge worth of model behaviour, using the inputs held across it.
  task automatic model_edge();
    int low;
    int g;
    bit trans;
    m_pmod1 = m_sq & (m_c < int'(volume)) & ~mute;
    m_pmod4 = ~mute;
    m_c = (m_c + 1) % (1 << DUTY_W);
    m_k++;
    // Tone: the square restarts one edge after the source changed.
    if (restart_due) begin
      seg_start = m_k;
      seg_init  = 1'b1;
      case (m_mode)
        M_IDLE:  seg_hp = int'(bg_hp);
        M_PLAY:  seg_hp = m_hp;
        default: seg_hp = 0;
      endcase
    end
    if (seg_hp == 0) m_sq = 1'b0;
    else             m_sq = 1'(int'(seg_init) ^ (((m_k - seg_start) / seg_hp) % 2));
    // Sequencing.
    low = -1;
    for (int i = 0; i < N_CH; i++) if (m_pend[i] && low < 0) low = i;
    g = -1;
    trans = 1'b0;
    m_done = '0;
    case (m_mode)
      M_IDLE: if (low >= 0) g = low;
      M_PLAY: begin
        if (tick && m_left == 1) begin
          m_done[m_ch] = 1'b1;
          m_mode = (GAP_TICKS > 0) ? M_QUIET : M_IDLE;
          m_gap = GAP_TICKS;
          trans = 1'b1;
        end else if (low >= 0 && low < m_ch) g = low;
        else if (tick) m_left--;
      end
      default: begin
        if (tick) begin
          if (m_gap == 1) begin
            if (low >= 0) g = low;
            else begin m_mode = M_IDLE; trans = 1'b1; end
          end else m_gap--;
        end
      end
    endcase
    if (g >= 0) begin
      m_mode = M_PLAY;
      m_ch = g;
      m_left = (len_of(g) == 0) ? 1 : len_of(g);
      m_hp = hp_of(g);
      m_pend[g] = 1'b0;
      trans = 1'b1;
    end
    for (int i = 0; i < N_CH; i++) if (sfx_req[i]) m_pend[i] = 1'b1;
    restart_due = trans;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("busy", busy, m_mode != M_IDLE);
    if (m_mode == M_PLAY) check("active_ch", active_ch, m_ch);
    check("done", done, m_done);
    check("pmod_1", pmod_1, m_pmod1);
    check("pmod_2", pmod_2, 1);
    check("pmod_4", pmod_4, m_pmod4);
    sfx_req = '0;
    tick = 1'b0;
  endtask

  task automatic run(input int n, input int tick_every);
    for (int i = 0; i < n; i++) begin
      tick = (tick_every > 0) && ((i % tick_every) == tick_every - 1);
      step();
    end
  endtask

  task automatic set_ch(input int i, input int hp, input int len);
    sfx_hp[i*HP_W +: HP_W]    = HP_W'(hp);
    sfx_len[i*LEN_W +: LEN_W] = LEN_W'(len);
  endtask

  // Hold reset while wiggling inputs; outputs must stay cleared throughout.
  task automatic hold_reset(input int n, input int bg);
    rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick = 1'($urandom_range(0, 1));
      sfx_req = N_CH'($urandom);
      bg_hp = HP_W'($urandom_range(0, 15));
      volume = DUTY_W'($urandom);
      mute = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("rst_pmod_1", pmod_1, 0);
      check("rst_pmod_4", pmod_4, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
    end
    tick = 1'b0;
    sfx_req = '0;
    bg_hp = HP_W'(bg);
    volume = 8'd255;
    mute = 1'b0;
    model_reset();
    #3 rst = 1'b1;
  endtask

  initial begin
    int t0;
    int t1;
    // Reset held with toggling inputs, then the background tone.
    hold_reset(6, 4);
    run(40, 0);

    // Single effect on channel 2: latency, duration, gap, return to background.
    set_ch(2, 3, 3);
    sfx_req = 4'b0100;
    step();
    check("lat_busy_t1", busy, 0);
    step();
    check("lat_busy_t2", busy, 1);
    check("lat_ch", active_ch, 2);
    run(40, 5);

    // Channel 3 preempted by channel 1.
    set_ch(3, 5, 6);
    sfx_req = 4'b1000;
    step();
    run(12, 5);
    set_ch(1, 2, 2);
    sfx_req = 4'b0010;
    step();
    step();
    check("preempt_ch", active_ch, 1);
    run(40, 4);

    // Simultaneous requests on channels 0 and 1.
    set_ch(0, 3, 2);
    set_ch(1, 4, 2);
    sfx_req = 4'b0011;
    t0 = -1;
    t1 = -1;
    for (int i = 0; i < 80; i++) begin
      tick = (i % 4) == 3;
      step();
      if (done[0] && t0 < 0) t0 = i;
      if (done[1] && t1 < 0) t1 = i;
    end
    check("done_order", (t0 >= 0) && (t1 > t0), 1);

    // Zero length, zero half-period, mute.
    set_ch(2, 3, 0);
    sfx_req = 4'b0100;
    run(30, 3);
    set_ch(3, 0, 2);
    sfx_req = 4'b1000;
    run(30, 3);
    run(20, 0);
    mute = 1'b1;
    step();
    check("mute_pmod_4", pmod_4, 0);
    check("mute_pmod_1", pmod_1, 0);
    run(10, 0);
    mute = 1'b0;
    run(10, 0);

    // Randomized epochs, each starting with a (likely mid-effect) reset.
    for (int e = 0; e < 4; e++) begin
      hold_reset(3, (e == 2) ? 0 : int'($urandom_range(1, 12)));
      volume = DUTY_W'($urandom);
      for (int n = 0; n < 1500; n++) begin
        tick = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < N_CH; i++) begin
          if (!m_pend[i] && $urandom_range(0, 7) == 0)
            set_ch(i, ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 15)),
                   int'($urandom_range(0, 5)));
          sfx_req[i] = ($urandom_range(0, 15) == 0);
        end
        if ($urandom_range(0, 63) == 0) volume = DUTY_W'($urandom);
        if ($urandom_range(0, 49) == 0) mute = ~mute;
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
